// File: rtl/fifo_arb_pkg.sv
// +----------------------------------------------------------------------+
// | fifo_arb_pkg: shared types and defaults for the FIFO access arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    localparam int         c_DEFAULT_DATA_W   = 8;
    localparam int         c_DEFAULT_TICK_DIV = 625;
    localparam logic [1:0] c_STARVE_THRESH    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fifo_access_arbiter_rr_select.sv
// +----------------------------------------------------------------------+
// | rr_select: combinational round-robin picker, searches from ptr+1.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!valid && eligible[(int'(ptr) + off) % N]) begin
                grant[(int'(ptr) + off) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_access_arbiter.sv
// +----------------------------------------------------------------------+
// | fifo_access_arbiter: slot-paced arbiter sharing one FIFO command     |
// | port between NUM_REQ writers and one reader (read has priority).     |
// | Optional read-starvation guard: FIFO_ARB_STARVE_GUARD_EN             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = c_DEFAULT_DATA_W,
    parameter int TICK_DIV = c_DEFAULT_TICK_DIV
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_ack,
    input  logic                      rd_req,
    output logic                      rd_ack,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      fifo_en,
    output logic                      fifo_wr,
    output logic                      fifo_rd,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic [DATA_W-1:0]         fifo_dout,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic                      busy
);

    localparam int c_CNT_W = $clog2(TICK_DIV);
    localparam int c_PTR_W = $clog2(NUM_REQ);

    arb_state_t           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_is_read;

    logic                 w_tick;
    logic [NUM_REQ-1:0]   w_wr_elig;
    logic                 w_rd_elig;
    logic [NUM_REQ-1:0]   w_wr_grant;
    logic                 w_wr_valid;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic [DATA_W-1:0]    w_grant_data;
    logic                 w_read_wins;

    assign w_tick    = (r_cnt == c_CNT_W'(TICK_DIV - 1));
    assign w_wr_elig = wr_req & {NUM_REQ{~fifo_full}};
    assign w_rd_elig = rd_req & ~fifo_empty;

    rr_select #(
        .N (NUM_REQ)
    ) u_rr_select (
        .eligible (w_wr_elig),
        .ptr      (r_ptr),
        .grant    (w_wr_grant),
        .valid    (w_wr_valid)
    );

    always_comb begin
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_wr_grant[i]) begin
                w_grant_idx  = c_PTR_W'(i);
                w_grant_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef FIFO_ARB_STARVE_GUARD_EN
    logic [1:0] r_rd_streak;
    logic       w_arb_slot;

    assign w_arb_slot  = (r_state == ST_IDLE) && w_tick;
    // After three reads that passed over waiting writers, writers take the slot.
    assign w_read_wins = w_rd_elig && !(w_wr_valid && (r_rd_streak == c_STARVE_THRESH));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_streak <= 2'd0;
        end else if (w_arb_slot) begin
            if (w_read_wins && w_wr_valid) begin
                r_rd_streak <= r_rd_streak + 2'd1;
            end else if (!w_read_wins && w_wr_valid) begin
                r_rd_streak <= 2'd0;
            end
        end
    end
`else
    assign w_read_wins = w_rd_elig;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ptr     <= c_PTR_W'(NUM_REQ - 1);
            r_gnt     <= '0;
            r_is_read <= 1'b0;
            wr_ack    <= '0;
            rd_ack    <= 1'b0;
            rd_data   <= '0;
            fifo_en   <= 1'b0;
            fifo_wr   <= 1'b0;
            fifo_rd   <= 1'b0;
            fifo_din  <= '0;
            busy      <= 1'b0;
        end else begin
            r_cnt  <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
            wr_ack <= '0;
            rd_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        if (w_read_wins) begin
                            r_state   <= ST_ISSUE;
                            r_is_read <= 1'b1;
                            fifo_en   <= 1'b1;
                            fifo_rd   <= 1'b1;
                            busy      <= 1'b1;
                        end else if (w_wr_valid) begin
                            r_state   <= ST_ISSUE;
                            r_is_read <= 1'b0;
                            r_gnt     <= w_wr_grant;
                            r_ptr     <= w_grant_idx;
                            fifo_en   <= 1'b1;
                            fifo_wr   <= 1'b1;
                            fifo_din  <= w_grant_data;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_tick) begin
                        r_state <= ST_ACK;
                        fifo_en <= 1'b0;
                        fifo_wr <= 1'b0;
                        fifo_rd <= 1'b0;
                        if (r_is_read) begin
                            rd_ack  <= 1'b1;
                            rd_data <= fifo_dout;
                        end else begin
                            wr_ack <= r_gnt;
                        end
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    fifo_en <= 1'b0;
                    fifo_wr <= 1'b0;
                    fifo_rd <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_access_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fifo_access_arbiter: directed self-checking bench, TICK_DIV=4.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_access_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int TICK_DIV = 4;

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_ack;
    logic                      rd_req;
    logic                      rd_ack;
    logic [DATA_W-1:0]         rd_data;
    logic                      fifo_en;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic [DATA_W-1:0]         fifo_din;
    logic [DATA_W-1:0]         fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    fifo_access_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .fifo_en    (fifo_en),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter sits at 0 after release, so the first ISSUE is seen 4 steps later.
    task automatic do_reset();
        reset      = 1'b0;
        wr_req     = '0;
        rd_req     = 1'b0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (fifo_en !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("issue_seen", {31'd0, fifo_en}, 32'd1);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (wr_ack === '0 && rd_ack !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check("ack_seen", {31'd0, (|wr_ack) | rd_ack}, 32'd1);
    endtask

    initial begin
        int  n;
        logic en_seen;

        reset     = 1'b0;
        wr_req    = '0;
        wr_data   = '0;
        rd_req    = 1'b0;
        fifo_dout = 8'h00;
        fifo_full = 1'b0;
        fifo_empty = 1'b0;

        // Reset values
        do_reset();
        check("reset_cmd", {28'd0, fifo_en, fifo_wr, fifo_rd, busy}, 32'd0);
        check("reset_ack", {27'd0, wr_ack, rd_ack}, 32'd0);
        check("reset_data", {16'd0, fifo_din, rd_data}, 32'd0);

        // Single write with exact slot timing
        wr_req  = 4'b0001;
        wr_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        repeat (3) step();
        check("sw_pre_tick_en", {31'd0, fifo_en}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("sw_issue_cmd", {28'd0, fifo_en, fifo_wr, fifo_rd, busy}, 32'b1101);
            check("sw_issue_din", {24'd0, fifo_din}, 32'hA5);
            check("sw_issue_noack", {28'd0, wr_ack}, 32'd0);
        end
        step();
        check("sw_ack", {28'd0, wr_ack}, 32'b0001);
        check("sw_ack_cmd", {28'd0, fifo_en, fifo_wr, fifo_rd, busy}, 32'b0001);
        wr_req = '0;
        step();
        check("sw_ack_pulse", {28'd0, wr_ack}, 32'd0);
        check("sw_idle_busy", {31'd0, busy}, 32'd0);
        check("sw_din_hold", {24'd0, fifo_din}, 32'hA5);

        // Round robin from reset: 0,1,2,3,0
        do_reset();
        wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
        wr_req  = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_issue(n);
            check("rr_wr", {30'd0, fifo_wr, fifo_rd}, 32'b10);
            check("rr_din", {24'd0, fifo_din}, 32'h10 + (g % 4));
            wait_ack(n);
            check("rr_ack_lat", n, 32'd4);
            check("rr_ack", {28'd0, wr_ack}, 32'd1 << (g % 4));
        end
        wr_req = '0;

        // Read priority and read data capture
        do_reset();
        rd_req    = 1'b1;
        wr_req    = 4'b0010;
        fifo_dout = 8'h3C;
        wait_issue(n);
        check("rp_first_lat", n, 32'd4);
        check("rp_first_rd", {30'd0, fifo_wr, fifo_rd}, 32'b01);
        wait_ack(n);
        check("rp_rd_ack", {27'd0, wr_ack, rd_ack}, 32'b00001);
        check("rp_rd_data", {24'd0, rd_data}, 32'h3C);
        rd_req = 1'b0;
        wait_issue(n);
        check("rp_wr_lat", n, 32'd4);
        check("rp_wr_din", {22'd0, fifo_wr, fifo_rd, fifo_din}, {22'd0, 2'b10, 8'h11});
        wait_ack(n);
        check("rp_wr_ack", {27'd0, wr_ack, rd_ack}, 32'b00100);
        wr_req = '0;

        // Full blocks writes
        do_reset();
        fifo_full = 1'b1;
        wr_req    = 4'b0001;
        wr_data   = {8'h00, 8'h00, 8'h00, 8'h5A};
        en_seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            en_seen = en_seen | fifo_en;
        end
        check("full_blocks", {31'd0, en_seen}, 32'd0);
        fifo_full = 1'b0;
        wait_issue(n);
        check("full_release_lat", n, 32'd4);
        check("full_release_din", {23'd0, fifo_wr, fifo_din}, {23'd0, 1'b1, 8'h5A});
        wait_ack(n);
        wr_req = '0;

        // Empty blocks reads
        do_reset();
        fifo_empty = 1'b1;
        rd_req     = 1'b1;
        en_seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            en_seen = en_seen | fifo_en;
        end
        check("empty_blocks", {31'd0, en_seen}, 32'd0);
        fifo_empty = 1'b0;
        wait_issue(n);
        check("empty_release_lat", n, 32'd4);
        check("empty_release_rd", {31'd0, fifo_rd}, 32'd1);
        wait_ack(n);
        rd_req = 1'b0;

        // Reset during the second ISSUE cycle
        do_reset();
        wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
        wr_req  = 4'b0100;
        wait_issue(n);
        step();
        reset = 1'b0;
        step();
        check("rst_mid_cmd", {28'd0, fifo_en, fifo_wr, fifo_rd, busy}, 32'd0);
        check("rst_mid_noack", {27'd0, wr_ack, rd_ack}, 32'd0);
        wr_req = 4'b1111;
        step();
        reset = 1'b1;
        wait_issue(n);
        check("rst_mid_relat", n, 32'd4);
        check("rst_mid_first", {24'd0, fifo_din}, 32'h10);
        wait_ack(n);
        check("rst_mid_ack0", {28'd0, wr_ack}, 32'b0001);
        wr_req = '0;

        // Continuous reads with a waiting writer
        do_reset();
        rd_req    = 1'b1;
        wr_req    = 4'b0001;
        wr_data   = {8'h00, 8'h00, 8'h00, 8'h77};
        fifo_dout = 8'hC3;
        for (int g = 0; g < 4; g++) begin
            wait_issue(n);
`ifdef FIFO_ARB_STARVE_GUARD_EN
            check("sg_kind", {30'd0, fifo_wr, fifo_rd}, (g == 3) ? 32'b10 : 32'b01);
`else
            check("sg_kind", {30'd0, fifo_wr, fifo_rd}, 32'b01);
`endif
            wait_ack(n);
        end
        rd_req = 1'b0;
        wr_req = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
